esfa_vector_loader: RTL and testbench
=====================================

ESFA_VECTOR_LOADER -- requirements
Module: esfa_vector_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, SHALL give the vector RAM capacity in 64-bit words, terminator included.
REQ-002 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; arms a new load session.
REQ-005 s_valid  input  1  byte-stream valid.
REQ-006 s_data  input  8  byte-stream payload.
REQ-007 s_last  input  1  marks the final byte of the stream; qualified by s_valid.
REQ-008 s_ready  output  1  loader accepts a byte when s_valid && s_ready on a clock edge.
REQ-009 wr_en  output  1  one-cycle RAM write strobe.
REQ-010 wr_addr  output  32  RAM byte address; word k SHALL be at address 8*k.
REQ-011 wr_data  output  64  RAM write word.
REQ-012 busy  output  1  high in any state other than IDLE and DONE.
REQ-013 done  output  1  high while in DONE.
REQ-014 overflow  output  1  sticky; data exceeded capacity during the current session.
REQ-015 word_count  output  16  data words written this session, terminator excluded.

Function
REQ-016 The block SHALL be an FSM with states IDLE, COLLECT, WRITE, TERM and DONE.
REQ-017 IDLE --start--> COLLECT; DONE --start--> COLLECT; start SHALL be ignored in COLLECT, WRITE and TERM.
REQ-018 On entry to COLLECT from start, the block SHALL clear the byte index, word_count, overflow and the address pointer to 0.
REQ-019 s_ready SHALL be 1 only in COLLECT, and 0 in every other state.
REQ-020 Accepted byte k (0..7) of a word SHALL be packed into wr_data bits [8k+7:8k], i.e. little-endian; byte 0 carries isMutating in bit 0, expectedResultBool in bit 1 and endOfProgram in bit 2.
REQ-021 The 8th accepted byte, or any byte with s_last=1, SHALL move the FSM to WRITE on the same edge.
REQ-022 A word completed by s_last before byte 7 SHALL have its unfilled byte lanes written as 0.
REQ-023 WRITE SHALL last exactly one cycle, with wr_en=1, wr_addr=8*word_count and the packed word on wr_data; on the following edge word_count SHALL increment by 1 and the byte index SHALL clear.
REQ-024 Latency: byte accepted at edge N SHALL produce wr_en high in cycle N+1; sustained throughput SHALL be 8 bytes per 9 cycles.
REQ-025 WRITE SHALL go to TERM if the word was ended by s_last, otherwise to COLLECT.
REQ-026 TERM SHALL last one cycle, with wr_en=1, wr_addr=8*word_count and wr_data=64'h0000_0000_0000_0004 (endOfProgram only); it SHALL then go to DONE.
REQ-027 Capacity: at most DEPTH_WORDS-1 data words SHALL be written; a word completing when word_count==DEPTH_WORDS-1 SHALL NOT be written, overflow SHALL be set, and the FSM SHALL go directly to TERM.
REQ-028 After an overflow, later stream bytes SHALL be back-pressured (s_ready=0) until the next start.
REQ-029 wr_en SHALL be 0 in IDLE, COLLECT and DONE; wr_addr and wr_data are don't-care when wr_en=0.
REQ-030 word_count SHALL hold its final value in DONE until the next start.

Reset
REQ-031 reset=1 SHALL force IDLE, s_ready=0, wr_en=0, busy=0, done=0, overflow=0, word_count=0, and clear the address pointer and byte index, on the same edge, from any state.
REQ-032 reset SHALL take priority over start and over stream activity; a partially assembled word SHALL be discarded and no write SHALL issue.

Verification
REQ-033 start, then 16 bytes 0x00..0x0F with s_last on the 16th -> writes {addr 0, 64'h0706050403020100}, {addr 8, 64'h0F0E0D0C0B0A0908}, {addr 16, 64'h4}; done=1, word_count=2, overflow=0.
REQ-034 start, then 3 bytes 0xAA,0xBB,0xCC with s_last on 0xCC -> writes {addr 0, 64'h0000000000CCBBAA}, then {addr 8, 64'h4}; word_count=1.
REQ-035 DEPTH_WORDS=4, start, then 40 bytes with no s_last -> 3 data words at 0/8/16, terminator at 24, overflow=1, done=1, s_ready held at 0.
REQ-036 Continuous s_valid -> s_ready drops for exactly one cycle after every 8th byte; the 8th byte is accepted at edge N and wr_en is high in cycle N+1.
REQ-037 reset asserted after 5 bytes of a word -> no wr_en, and all outputs are at reset values on the next cycle; a following start plus 8 bytes writes to addr 0.
REQ-038 start pulsed mid-COLLECT and again in DONE -> the first is ignored; the second clears done, overflow and word_count, and restarts at addr 0.

Source files
------------

// File: rtl/esfa_vector_loader_if.sv
// Byte-stream input and RAM write port of the vector loader, bundled as one interface.
// The master side drives the stream and observes writes; the slave side is the loader.
// Widths are fixed: 8-bit stream bytes, 32-bit byte address, 64-bit write words.
interface esfa_vector_loader_if;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/esfa_vector_loader.sv
// Packs a byte stream into little-endian 64-bit words and writes them to a vector RAM, then appends an endOfProgram terminator word.
// Latency: the byte completing a word at edge N gives wr_en in the cycle right after edge N; throughput is 8 bytes per 9 cycles.
// Backpressure: s_ready is high only while collecting; it drops for the write cycle and stays low after termination or overflow until the next start.
module esfa_vector_loader #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  esfa_vector_loader_if.slave      bus,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [15:0]              word_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_TERM    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Last data slot: the final RAM word is reserved for the terminator.
  localparam logic [15:0] LAST_SLOT = 16'(DEPTH_WORDS - 1);
  localparam logic [63:0] TERM_WORD = 64'h0000_0000_0000_0004;

  state_t      state_q, state_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [63:0] word_q, word_d;
  logic        ended_q, ended_d;       // current word was closed by s_last
  logic [15:0] word_count_q, word_count_d;
  logic        overflow_q, overflow_d;

  // Next-state, datapath updates and handshake/write outputs.
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    ended_d      = ended_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    bus.s_ready  = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = {13'b0, word_count_q, 3'b000};
    bus.wr_data  = word_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_COLLECT;
          byte_idx_d   = 3'd0;
          word_d       = 64'd0;
          ended_d      = 1'b0;
          word_count_d = 16'd0;
          overflow_d   = 1'b0;
        end
      end
      S_COLLECT: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = bus.s_data;
          byte_idx_d = byte_idx_q + 3'd1;
          ended_d    = bus.s_last;
          if ((byte_idx_q == 3'd7) || bus.s_last) begin
            if (word_count_q == LAST_SLOT) begin
              // No room for another data word: drop it and terminate.
              overflow_d = 1'b1;
              state_d    = S_TERM;
            end else begin
              state_d = S_WRITE;
            end
          end
        end
      end
      S_WRITE: begin
        bus.wr_en    = 1'b1;
        word_count_d = word_count_q + 16'd1;
        byte_idx_d   = 3'd0;
        word_d       = 64'd0;   // unfilled lanes of a short word read as zero
        state_d      = ended_q ? S_TERM : S_COLLECT;
      end
      S_TERM: begin
        bus.wr_en   = 1'b1;
        bus.wr_data = TERM_WORD;
        state_d     = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset that discards any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= 3'd0;
      word_q       <= 64'd0;
      ended_q      <= 1'b0;
      word_count_q <= 16'd0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      ended_q      <= ended_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign busy       = (state_q == S_COLLECT) || (state_q == S_WRITE) || (state_q == S_TERM);
  assign done       = (state_q == S_DONE);
  assign overflow   = overflow_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_esfa_vector_loader.sv
// Directed and randomized sessions against a byte-list reference model of the loader.
// Writes are captured on the falling edge and compared with the model's expected write list.
// Capacity is kept small so overflow termination is exercised often.
module tb_esfa_vector_loader;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, overflow;
  logic [15:0] word_count;

  esfa_vector_loader_if bus();

  esfa_vector_loader #(.DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus.slave),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;
  int cyc      = 0;

  logic [7:0]  stim[$];
  logic [31:0] got_addr[$];
  logic [63:0] got_data[$];
  int          got_cyc[$];
  logic [31:0] exp_addr[$];
  logic [63:0] exp_data[$];
  int          acc_edge[$];
  int          exp_consumed;
  int          exp_wc;
  bit          exp_ovf;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      got_addr.push_back(bus.wr_addr);
      got_data.push_back(bus.wr_data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: chop the offered bytes into 8-byte words, stop at s_last or when capacity runs out.
  task automatic build_model(input int n, input bit last_final);
    logic [63:0] w;
    int idx;
    int nw;
    exp_addr.delete();
    exp_data.delete();
    w = 64'd0; idx = 0; nw = 0; exp_ovf = 1'b0; exp_consumed = 0;
    for (int i = 0; i < n; i++) begin
      bit lst;
      lst = last_final && (i == n - 1);
      w[8*idx +: 8] = stim[i];
      idx++;
      exp_consumed++;
      if (idx == 8 || lst) begin
        if (nw == DEPTH - 1) begin
          exp_ovf = 1'b1;
          break;
        end
        exp_addr.push_back(32'(8 * nw));
        exp_data.push_back(w);
        nw++;
        w = 64'd0;
        idx = 0;
        if (lst) break;
      end
    end
    exp_wc = nw;
    if (exp_ovf || last_final) begin
      exp_addr.push_back(32'(8 * nw));
      exp_data.push_back(64'h4);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, output bit ok);
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    bus.s_last  = last;
    for (int t = 0; t < 20; t++) begin
      if (bus.s_ready === 1'b1) begin
        ok = 1'b1;
        acc_edge.push_back(cyc + 1);
      end
      @(negedge clk);
      if (ok) break;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_session(input int n, input bit last_final, input bit gaps, input int mid_start);
    bit ok;
    int acc;
    build_model(n, last_final);
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    acc_edge.delete();
    pulse_start();
    check("start_clears_done", 64'(done), 64'd0);
    check("start_clears_ovf", 64'(overflow), 64'd0);
    check("start_clears_wc", 64'(word_count), 64'd0);
    check("start_sets_busy", 64'(busy), 64'd1);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      if (i == mid_start) begin
        bus.s_valid = 1'b0;
        pulse_start();
        check("mid_start_wc_kept", 64'(word_count), 64'(i / 8));
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      send_byte(stim[i], last_final && (i == n - 1), ok);
      if (!ok) break;
      acc++;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    for (int t = 0; t < 200 && done !== 1'b1; t++) @(negedge clk);
    check("accepted_bytes", 64'(acc), 64'(exp_consumed));
    check("write_count", 64'(got_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check($sformatf("wr%0d_addr", i), 64'(got_addr[i]), 64'(exp_addr[i]));
      check($sformatf("wr%0d_data", i), got_data[i], exp_data[i]);
    end
    check("done", 64'(done), 64'd1);
    check("busy_in_done", 64'(busy), 64'd0);
    check("word_count", 64'(word_count), 64'(exp_wc));
    check("overflow", 64'(overflow), 64'(exp_ovf));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 64'(bus.s_ready), 64'd0);
    check("rst_wr_en", 64'(bus.wr_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_no_ready", 64'(bus.s_ready), 64'd0);

    // Two full words plus terminator, streamed with s_valid held high.
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(8'(i));
    run_session(16, 1'b1, 1'b0, -1);
    check("seq16_w0", got_data[0], 64'h0706050403020100);
    check("seq16_w1", got_data[1], 64'h0F0E0D0C0B0A0908);
    check("seq16_term_addr", 64'(got_addr[2]), 64'd16);
    check("seq16_wc", 64'(word_count), 64'd2);
    // The 8th byte is accepted at edge N; its write shows right after edge N.
    check("lat_word0", 64'(got_cyc[0]), 64'(acc_edge[7]));
    check("lat_word1", 64'(got_cyc[1]), 64'(acc_edge[15]));
    check("burst_gap0", 64'(acc_edge[7] - acc_edge[0]), 64'd7);
    check("ready_drop_one", 64'(acc_edge[8] - acc_edge[7]), 64'd2);

    // Short word closed by s_last: upper lanes are zero.
    stim.delete();
    stim.push_back(8'hAA); stim.push_back(8'hBB); stim.push_back(8'hCC);
    run_session(3, 1'b1, 1'b0, -1);
    check("short_w0", got_data[0], 64'h0000000000CCBBAA);
    check("short_term_addr", 64'(got_addr[1]), 64'd8);
    check("short_wc", 64'(word_count), 64'd1);

    // Capacity overflow: 40 bytes, no s_last.
    stim.delete();
    for (int i = 0; i < 40; i++) stim.push_back(8'($urandom));
    run_session(40, 1'b0, 1'b0, -1);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_wc", 64'(word_count), 64'd3);
    check("ovf_term_addr", 64'(got_addr[3]), 64'd24);
    bus.s_valid = 1'b1;
    for (int t = 0; t < 5; t++) begin
      check("ovf_backpressure", 64'(bus.s_ready), 64'd0);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;

    // Start in DONE after overflow clears status; start mid-collect is ignored.
    stim.delete();
    for (int i = 0; i < 11; i++) stim.push_back(8'($urandom));
    run_session(11, 1'b1, 1'b0, 3);
    check("restart_addr0", 64'(got_addr[0]), 64'd0);

    // Reset partway through a word: nothing written, outputs back to reset values.
    got_addr.delete();
    got_data.delete();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      bit ok;
      send_byte(8'(8'h50 + i), 1'b0, ok);
    end
    reset = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h77;
    bus.s_last  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("mid_rst_s_ready", 64'(bus.s_ready), 64'd0);
    check("mid_rst_wr_en", 64'(bus.wr_en), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_wc", 64'(word_count), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    @(negedge clk);
    check("mid_rst_no_write", 64'(got_addr.size()), 64'd0);
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
    run_session(8, 1'b1, 1'b0, -1);
    check("post_rst_addr0", 64'(got_addr[0]), 64'd0);

    // Random sessions with idle gaps in the stream.
    for (int s = 0; s < 10; s++) begin
      int n;
      bit lf;
      n = $urandom_range(1, 40);
      lf = (n < 8 * DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
      run_session(n, lf, 1'b1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
